// File: rtl/mem_access_stage.sv
// Memory stage: drives loads/stores over a req/gnt/rvalid data bus, formats
// store lanes and load results, and stalls upstream while a transaction is open.
module mem_access_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [XLEN-1:0]        ex_result,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [2:0]             funct3,
    input  logic                   wb_reg_write,
    input  logic                   wb_memtoreg,
    input  logic [RFIDX_WIDTH-1:0] rd_index,
    output logic                   dbus_req,
    output logic                   dbus_we,
    output logic [XLEN-1:0]        dbus_addr,
    output logic [XLEN-1:0]        dbus_wdata,
    output logic [3:0]             dbus_wstrb,
    input  logic                   dbus_gnt,
    input  logic                   dbus_rvalid,
    input  logic [XLEN-1:0]        dbus_rdata,
    output logic [XLEN-1:0]        m_data,
    output logic [XLEN-1:0]        ex_result_out,
    output logic                   wb_reg_write_out,
    output logic                   wb_memtoreg_out,
    output logic [RFIDX_WIDTH-1:0] rd_index_out,
    output logic                   mem_stall,
    output logic                   misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic            is_load_q;
    logic            latch_en;
    logic            is_mem, aligned, mem_op;
    logic [XLEN-1:0] wdata_fmt;
    logic [3:0]      wstrb_fmt;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_fmt;

    assign is_mem  = in_valid & (mem_read | mem_write);
    assign aligned = (funct3[1:0] == 2'b00)
                   | ((funct3[1:0] == 2'b01) & ~ex_result[0])
                   | ((funct3[1:0] == 2'b10) & (ex_result[1:0] == 2'b00));
    assign mem_op  = is_mem & aligned;

    // Bus payload comes straight from EX/MEM, which holds steady while stalled.
    assign dbus_addr  = {ex_result[XLEN-1:2], 2'b00};
    assign dbus_we    = dbus_req & mem_write;
    assign dbus_wdata = wdata_fmt;
    assign dbus_wstrb = (dbus_req & mem_write) ? wstrb_fmt : 4'b0000;

    assign ex_result_out   = ex_result;
    assign wb_memtoreg_out = wb_memtoreg;
    assign rd_index_out    = rd_index;

    // Store lane replication and byte strobes
    always_comb begin
        wdata_fmt = rs2_data;
        wstrb_fmt = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata_fmt = {4{rs2_data[7:0]}};
                wstrb_fmt = 4'b0001 << ex_result[1:0];
            end
            2'b01: begin
                wdata_fmt = {2{rs2_data[15:0]}};
                wstrb_fmt = 4'b0011 << ex_result[1:0];
            end
            default: ;
        endcase
    end

    // Load extraction uses the offset/funct3 captured when the request was issued
    always_comb begin
        ld_byte  = dbus_rdata[{off_q, 3'b000} +: 8];
        ld_half  = dbus_rdata[{off_q[1], 4'b0000} +: 16];
        load_fmt = dbus_rdata;
        case (f3_q)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_fmt = {24'd0, ld_byte};
            3'b101:  load_fmt = {16'd0, ld_half};
            default: load_fmt = dbus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            is_load_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                off_q     <= ex_result[1:0];
                f3_q      <= funct3;
                is_load_q <= mem_read;
            end
        end
    end

    // Next state and stage outputs; everything idles while rst is high
    always_comb begin
        state_nxt        = state;
        latch_en         = 1'b0;
        dbus_req         = 1'b0;
        mem_stall        = 1'b0;
        wb_reg_write_out = 1'b0;
        misalign         = 1'b0;
        m_data           = '0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        dbus_req  = 1'b1;
                        mem_stall = 1'b1;
                        latch_en  = 1'b1;
                        state_nxt = dbus_gnt ? S_RESP : S_REQ;
                    end else begin
                        wb_reg_write_out = in_valid & wb_reg_write & ~is_mem;
                        misalign         = is_mem & ~aligned;
                    end
                end
                S_REQ: begin
                    dbus_req  = 1'b1;
                    mem_stall = 1'b1;
                    if (dbus_gnt) state_nxt = S_RESP;
                end
                S_RESP: begin
                    if (dbus_rvalid) begin
                        state_nxt        = S_IDLE;
                        wb_reg_write_out = wb_reg_write;
                        m_data           = is_load_q ? load_fmt : '0;
                    end else begin
                        mem_stall = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, bus wait states,
// misalignment, reset mid-transaction and ALU pass-through.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] ex_result;
    logic [31:0] rs2_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        wb_reg_write;
    logic        wb_memtoreg;
    logic [4:0]  rd_index;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic [31:0] m_data;
    logic [31:0] ex_result_out;
    logic        wb_reg_write_out;
    logic        wb_memtoreg_out;
    logic [4:0]  rd_index_out;
    logic        mem_stall;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ex_result(ex_result),
        .rs2_data(rs2_data), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .wb_reg_write(wb_reg_write), .wb_memtoreg(wb_memtoreg),
        .rd_index(rd_index), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .m_data(m_data), .ex_result_out(ex_result_out),
        .wb_reg_write_out(wb_reg_write_out), .wb_memtoreg_out(wb_memtoreg_out),
        .rd_index_out(rd_index_out), .mem_stall(mem_stall), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks run 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; mem_read = 0; mem_write = 0; funct3 = 3'b000;
        ex_result = 0; rs2_data = 0; wb_reg_write = 0; wb_memtoreg = 0;
        rd_index = 0; dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
    endtask

    // Load with grant in the request cycle and response in the following cycle
    task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [31:0] exp);
        in_valid = 1; mem_read = 1; mem_write = 0; funct3 = f3; ex_result = addr;
        wb_reg_write = 1; wb_memtoreg = 1; dbus_gnt = 1; dbus_rvalid = 0;
        settle();
        chk({tag, "_req"}, 32'(dbus_req), 32'd1);
        chk({tag, "_stall"}, 32'(mem_stall), 32'd1);
        step();
        dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = rdata;
        settle();
        chk({tag, "_mdata"}, m_data, exp);
        chk({tag, "_wb"}, 32'(wb_reg_write_out), 32'd1);
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        // A load presented during reset must not reach the bus
        in_valid = 1; mem_read = 1; wb_reg_write = 1; dbus_gnt = 1;
        settle();
        chk("rst_req", 32'(dbus_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_wb", 32'(wb_reg_write_out), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        step();
        step();
        rst = 0;
        idle_inputs();
        step();

        // LB at 0x1003, grant same cycle, response one cycle later
        in_valid = 1; mem_read = 1; funct3 = 3'b000; ex_result = 32'h1003;
        wb_reg_write = 1; wb_memtoreg = 1; rd_index = 5'd5; dbus_gnt = 1;
        settle();
        chk("lb_req", 32'(dbus_req), 32'd1);
        chk("lb_we", 32'(dbus_we), 32'd0);
        chk("lb_addr", dbus_addr, 32'h1000);
        chk("lb_wstrb", 32'(dbus_wstrb), 32'd0);
        chk("lb_stall0", 32'(mem_stall), 32'd1);
        chk("lb_wb0", 32'(wb_reg_write_out), 32'd0);
        chk("lb_mdata0", m_data, 32'd0);
        step();
        dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h80112233;
        settle();
        chk("lb_mdata", m_data, 32'hFFFFFF80);
        chk("lb_stall1", 32'(mem_stall), 32'd0);
        chk("lb_wb1", 32'(wb_reg_write_out), 32'd1);
        chk("lb_req1", 32'(dbus_req), 32'd0);
        chk("lb_rd", 32'(rd_index_out), 32'd5);
        step();
        idle_inputs();
        settle();
        chk("lb_after_wb", 32'(wb_reg_write_out), 32'd0);
        chk("lb_after_mdata", m_data, 32'd0);

        // SH at 0x2002: upper halfword lanes
        in_valid = 1; mem_write = 1; funct3 = 3'b001; ex_result = 32'h2002;
        rs2_data = 32'h0000BEEF; dbus_gnt = 1;
        settle();
        chk("sh_addr", dbus_addr, 32'h2000);
        chk("sh_wdata", dbus_wdata, 32'hBEEFBEEF);
        chk("sh_wstrb", 32'(dbus_wstrb), 32'hC);
        chk("sh_we", 32'(dbus_we), 32'd1);
        chk("sh_req", 32'(dbus_req), 32'd1);
        step();
        dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'hFFFFFFFF;
        settle();
        chk("sh_stall_rv", 32'(mem_stall), 32'd0);
        chk("sh_mdata", m_data, 32'd0);
        chk("sh_wb", 32'(wb_reg_write_out), 32'd0);
        step();
        idle_inputs();

        // SB at offset 1 and SW strobes
        in_valid = 1; mem_write = 1; funct3 = 3'b000; ex_result = 32'h2001;
        rs2_data = 32'h123456A5; dbus_gnt = 1;
        settle();
        chk("sb_wdata", dbus_wdata, 32'hA5A5A5A5);
        chk("sb_wstrb", 32'(dbus_wstrb), 32'h2);
        step();
        dbus_gnt = 0; dbus_rvalid = 1;
        step();
        idle_inputs();
        in_valid = 1; mem_write = 1; funct3 = 3'b010; ex_result = 32'h2004;
        rs2_data = 32'hCAFEF00D; dbus_gnt = 1;
        settle();
        chk("sw_wdata", dbus_wdata, 32'hCAFEF00D);
        chk("sw_wstrb", 32'(dbus_wstrb), 32'hF);
        step();
        dbus_gnt = 0; dbus_rvalid = 1;
        step();
        idle_inputs();

        // LHU at 0x3000: no grant for two cycles, then three response wait cycles
        in_valid = 1; mem_read = 1; funct3 = 3'b101; ex_result = 32'h3000;
        wb_reg_write = 1; rd_index = 5'd9; dbus_gnt = 0;
        for (int c = 0; c < 6; c++) begin
            dbus_gnt = (c == 2);
            settle();
            chk($sformatf("lhu_stall_c%0d", c), 32'(mem_stall), 32'd1);
            chk($sformatf("lhu_wb_c%0d", c), 32'(wb_reg_write_out), 32'd0);
            if (c < 3) begin
                chk($sformatf("lhu_req_c%0d", c), 32'(dbus_req), 32'd1);
                chk($sformatf("lhu_addr_c%0d", c), dbus_addr, 32'h3000);
                chk($sformatf("lhu_wstrb_c%0d", c), 32'(dbus_wstrb), 32'd0);
            end else begin
                chk($sformatf("lhu_req_c%0d", c), 32'(dbus_req), 32'd0);
            end
            step();
        end
        dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h1234F00D;
        settle();
        chk("lhu_mdata", m_data, 32'h0000F00D);
        chk("lhu_stall_rv", 32'(mem_stall), 32'd0);
        chk("lhu_wb_rv", 32'(wb_reg_write_out), 32'd1);
        step();
        idle_inputs();

        // Back-to-back loads exercising sign/zero extension at other offsets
        quick_load("lbu1", 3'b100, 32'h1001, 32'h80112233, 32'h00000022);
        quick_load("lh2", 3'b001, 32'h1002, 32'h80112233, 32'hFFFF8011);
        quick_load("lw0", 3'b010, 32'h1004, 32'hDEADBEEF, 32'hDEADBEEF);

        // Misaligned LW: flagged for one cycle, no request, retires as bubble
        in_valid = 1; mem_read = 1; funct3 = 3'b010; ex_result = 32'h1002;
        wb_reg_write = 1; dbus_gnt = 1;
        settle();
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_req", 32'(dbus_req), 32'd0);
        chk("mis_wb", 32'(wb_reg_write_out), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        step();
        idle_inputs();
        settle();
        chk("mis_flag_next", 32'(misalign), 32'd0);
        chk("mis_req_next", 32'(dbus_req), 32'd0);

        // Reset while in RESP, then a stray response afterwards
        in_valid = 1; mem_read = 1; funct3 = 3'b010; ex_result = 32'h4000;
        wb_reg_write = 1; dbus_gnt = 1;
        step();
        dbus_gnt = 0;
        settle();
        chk("rr_in_resp_stall", 32'(mem_stall), 32'd1);
        rst = 1;
        settle();
        chk("rr_rst_stall", 32'(mem_stall), 32'd0);
        chk("rr_rst_wb", 32'(wb_reg_write_out), 32'd0);
        step();
        rst = 0;
        idle_inputs();
        dbus_rvalid = 1; dbus_rdata = 32'hDEADBEEF;
        settle();
        chk("rr_mdata", m_data, 32'd0);
        chk("rr_wb", 32'(wb_reg_write_out), 32'd0);
        chk("rr_stall", 32'(mem_stall), 32'd0);
        chk("rr_req", 32'(dbus_req), 32'd0);
        step();
        dbus_rvalid = 0;

        // ALU op passes straight through in the same cycle
        in_valid = 1; ex_result = 32'h55; rd_index = 5'd7; wb_reg_write = 1;
        wb_memtoreg = 0; dbus_rvalid = 1;
        settle();
        chk("alu_ex", ex_result_out, 32'h55);
        chk("alu_rd", 32'(rd_index_out), 32'd7);
        chk("alu_wb", 32'(wb_reg_write_out), 32'd1);
        chk("alu_m2r", 32'(wb_memtoreg_out), 32'd0);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        chk("alu_req", 32'(dbus_req), 32'd0);
        chk("alu_mdata", m_data, 32'd0);
        step();
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RISC-V core. Sits between the EX/MEM pipeline register and the mem_wb register.
- Executes loads and stores over a req/gnt/rvalid data bus.
- Aligns store data, generates byte strobes, and sign/zero-extends load data.
- Forwards writeback control and rd index to mem_wb. Stalls the pipeline while a bus transaction is outstanding.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported because strobes are 4 bits.
- RFIDX_WIDTH, 5, register-file index width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX/MEM holds a valid instruction
- ex_result  in  XLEN  ALU result; this is the effective address for loads/stores
- rs2_data  in  XLEN  store source data
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- funct3  in  3  access size/sign (RV32I encoding)
- wb_reg_write  in  1  writeback enable from EX/MEM
- wb_memtoreg  in  1  writeback source select from EX/MEM
- rd_index  in  RFIDX_WIDTH  destination register
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  XLEN  word-aligned address, {ex_result[XLEN-1:2],2'b00}
- dbus_wdata  out  XLEN  lane-replicated store data
- dbus_wstrb  out  4  byte strobes; 0 for reads
- dbus_gnt  in  1  request accepted
- dbus_rvalid  in  1  response valid (loads and stores)
- dbus_rdata  in  XLEN  read data
- m_data  out  XLEN  formatted load data, to mem_wb
- ex_result_out  out  XLEN  ex_result pass-through, to mem_wb
- wb_reg_write_out  out  1  gated writeback enable, to mem_wb
- wb_memtoreg_out  out  1  pass-through, to mem_wb
- rd_index_out  out  RFIDX_WIDTH  pass-through, to mem_wb
- mem_stall  out  1  holds all upstream stages
- misalign  out  1  one-cycle misaligned-access flag

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - On reset: FSM to IDLE; latched byte offset, funct3 and is_load cleared to 0; dbus_req=0.
  - During the rst cycle: mem_stall=0, wb_reg_write_out=0, misalign=0.
- FSM states: IDLE, REQ, RESP.
- mem_op = in_valid & (mem_read | mem_write) & aligned.
- Alignment rules:
  - Word access: addr[1:0]==0.
  - Halfword access: addr[0]==0.
  - Byte access: always aligned.
- IDLE:
  - If mem_op: drive dbus_req=1 combinationally in the same cycle and latch offset ex_result[1:0], funct3 and is_load.
  - If dbus_gnt is also high → RESP, otherwise → REQ. mem_stall=1 in both cases.
  - Non-memory in_valid instruction: pure pass-through. mem_stall=0; wb_reg_write_out=wb_reg_write & in_valid.
- REQ:
  - Hold dbus_req and all dbus_* outputs stable until dbus_gnt; on gnt → RESP.
  - mem_stall=1.
- RESP:
  - dbus_req=0. Wait for dbus_rvalid; on rvalid → IDLE.
  - In the rvalid cycle: mem_stall=0, wb_reg_write_out=wb_reg_write, and m_data is formatted from dbus_rdata.
  - In all other RESP cycles: mem_stall=1.
- Bubble rule: while mem_stall=1, wb_reg_write_out=0 so mem_wb captures a bubble.
- EX/MEM holds its outputs while stalled, so the pass-through signals stay stable.
- dbus_rvalid is ignored in IDLE and REQ. A stray response after reset has no effect.
- Store formatting:
  - SB: wdata = byte replicated x4; wstrb = 4'b0001<<off.
  - SH: wdata = half replicated x2; wstrb = 4'b0011<<off.
  - SW: wdata = rs2_data; wstrb = 4'b1111.
- Load formatting, using the latched off and funct3:
  - 000 LB: sign-extend byte at off.
  - 001 LH: sign-extend half at off.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - m_data=0 whenever the stage is not in the load rvalid cycle.
- Misaligned access:
  - No bus request; misalign=1 for that cycle; wb_reg_write_out=0; mem_stall=0.
  - The instruction retires as a bubble.
- Back-to-back memory ops: the next op may request in the cycle after rvalid (IDLE). There is no overlap.
- Reset mid-transaction (REQ or RESP): return to IDLE at the next edge and drop dbus_req. The outstanding response is discarded.

Test Plan:
- LB, ex_result=0x1003, gnt same cycle, rvalid 1 cycle later with rdata=0x80112233 → m_data=0xFFFFFF80; mem_stall high exactly 1 cycle; wb_reg_write_out=1 only in the rvalid cycle.
- SH, ex_result=0x2002, rs2_data=0x0000BEEF → dbus_addr=0x2000, wdata=0xBEEFBEEF, wstrb=4'b1100, we=1.
- LHU at 0x3000, gnt delayed 2 cycles, rvalid 3 cycles after gnt, rdata=0x1234F00D → dbus_req and all dbus_* stable for 3 cycles; mem_stall=1 for 6 cycles; m_data=0x0000F00D.
- LW at 0x1002 → misalign=1 for 1 cycle; dbus_req=0; wb_reg_write_out=0; mem_stall=0.
- rst asserted in RESP, rvalid pulsed 1 cycle after reset → FSM IDLE; no writeback; m_data=0.
- ALU op (mem_read=mem_write=0), ex_result=0x55, rd_index=7, wb_reg_write=1 → same-cycle pass-through; mem_stall=0.
